// File: rtl/seq_det_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seq_det_pkg
//  Description : Shared constants, FSM encoding and width helper for the
//                serial pattern-detection controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package seq_det_pkg;

    localparam int MAXLEN_DEF = 8;
    localparam int CW_DEF     = 8;
    localparam int TW_DEF     = 16;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SEARCH = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

    // Width needed to hold a pattern length in the range 0..maxlen
    function automatic int lw_of(input int maxlen);
        return $clog2(maxlen + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/seq_pattern_matcher.sv
`default_nettype none
// ============================================================================
//  Module      : seq_pattern_matcher
//  Description : Shift register plus bits-seen counter; flags a match of the
//                low len bits against pattern on the bit being shifted in.
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_pattern_matcher
    import seq_det_pkg::*;
#(
    parameter int MAXLEN = MAXLEN_DEF,
    parameter int LW     = lw_of(MAXLEN)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              shift_en,
    input  logic              x,
    input  logic [MAXLEN-1:0] pattern,
    input  logic [LW-1:0]     len,
    output logic              match
);

    localparam logic [LW-1:0] c_max_len = LW'(MAXLEN);

    logic [MAXLEN-1:0] r_sr;
    logic [MAXLEN-1:0] w_sr_next;
    logic [MAXLEN-1:0] w_mask;
    logic [LW-1:0]     r_bits;
    logic [LW-1:0]     w_bits_next;

    // Match is judged on the post-shift view so the hit lines up with the bit
    always_comb begin
        w_sr_next   = {r_sr[MAXLEN-2:0], x};
        w_bits_next = (r_bits == c_max_len) ? r_bits : r_bits + 1'b1;
        for (int i = 0; i < MAXLEN; i++) begin
            w_mask[i] = (i < int'(len));
        end
        match = shift_en && (w_bits_next >= len) &&
                (((w_sr_next ^ pattern) & w_mask) == '0);
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_sr   <= '0;
            r_bits <= '0;
        end else if (shift_en) begin
            r_sr   <= w_sr_next;
            r_bits <= w_bits_next;
        end
    end

endmodule
`default_nettype wire

// File: rtl/seq_detect_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : seq_detect_ctrl
//  Description : Programmable serial pattern detector with config handshake,
//                hit target, bit-count timeout and abort.
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_detect_ctrl
    import seq_det_pkg::*;
#(
    parameter  int MAXLEN = MAXLEN_DEF,
    parameter  int CW     = CW_DEF,
    parameter  int TW     = TW_DEF,
    localparam int LW     = lw_of(MAXLEN)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [MAXLEN-1:0] cfg_pattern,
    input  logic [LW-1:0]     cfg_len,
    input  logic [CW-1:0]     cfg_target,
    input  logic [TW-1:0]     cfg_timeout,
    output logic              cfg_err,
    input  logic              start,
    input  logic              abort,
    input  logic              x_valid,
    input  logic              x,
    output logic              busy,
    output logic              hit,
    output logic              done,
    output logic              timed_out,
    output logic [CW-1:0]     match_count
);

    localparam logic [LW-1:0] c_max_len = LW'(MAXLEN);
    localparam logic [CW-1:0] c_cnt_max = '1;

    logic [1:0]        r_state;
    logic [1:0]        w_state_next;
    logic              r_cfg_loaded;
    logic              r_cfg_err;
    logic              r_hit;
    logic              r_timed_out;
    logic [MAXLEN-1:0] r_pattern;
    logic [LW-1:0]     r_len;
    logic [CW-1:0]     r_target;
    logic [CW-1:0]     r_count;
    logic [CW-1:0]     w_count_next;
    logic [TW-1:0]     r_timeout;
    logic [TW-1:0]     r_timer;
    logic [TW-1:0]     w_timer_next;
    logic              w_cfg_acc;
    logic              w_cfg_ok;
    logic              w_start;
    logic              w_step;
    logic              w_match;
    logic              w_tgt;
    logic              w_tmo;

    // A config offer in the same cycle as start wins; start is dropped
    always_comb begin
        w_cfg_acc    = cfg_valid && (r_state == ST_IDLE);
        w_cfg_ok     = (cfg_len != '0) && (cfg_len <= c_max_len);
        w_start      = start && r_cfg_loaded && !w_cfg_acc && (r_state == ST_IDLE);
        w_step       = x_valid && !abort && (r_state == ST_SEARCH);
        w_timer_next = r_timer + 1'b1;
        w_count_next = (w_match && (r_count != c_cnt_max)) ? r_count + 1'b1 : r_count;
        w_tgt        = w_match && (r_target != '0) && (w_count_next == r_target);
        w_tmo        = w_step && (r_timeout != '0) && (w_timer_next == r_timeout) && !w_tgt;
    end

    seq_pattern_matcher #(
        .MAXLEN (MAXLEN),
        .LW     (LW)
    ) u_matcher (
        .clk      (clk),
        .rst      (rst),
        .clear    (w_start),
        .shift_en (w_step),
        .x        (x),
        .pattern  (r_pattern),
        .len      (r_len),
        .match    (w_match)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_start) begin
                    w_state_next = ST_SEARCH;
                end
            end
            ST_SEARCH: begin
                if (abort) begin
                    w_state_next = ST_IDLE;
                end else if (w_tgt || w_tmo) begin
                    w_state_next = ST_DONE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        cfg_ready = (r_state == ST_IDLE);
        busy      = (r_state == ST_SEARCH);
        done      = (r_state == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cfg_loaded <= 1'b0;
            r_cfg_err    <= 1'b0;
            r_pattern    <= '0;
            r_len        <= '0;
            r_target     <= '0;
            r_timeout    <= '0;
            r_hit        <= 1'b0;
            r_timer      <= '0;
            r_count      <= '0;
            r_timed_out  <= 1'b0;
        end else begin
            r_cfg_err <= w_cfg_acc && !w_cfg_ok;
            r_hit     <= w_match;
            if (w_cfg_acc && w_cfg_ok) begin
                r_pattern    <= cfg_pattern;
                r_len        <= cfg_len;
                r_target     <= cfg_target;
                r_timeout    <= cfg_timeout;
                r_cfg_loaded <= 1'b1;
            end
            if (w_start) begin
                r_timer     <= '0;
                r_count     <= '0;
                r_timed_out <= 1'b0;
            end else if (w_step) begin
                r_timer <= w_timer_next;
                r_count <= w_count_next;
                if (w_tmo) begin
                    r_timed_out <= 1'b1;
                end
            end
        end
    end

    assign cfg_err     = r_cfg_err;
    assign hit         = r_hit;
    assign timed_out   = r_timed_out;
    assign match_count = r_count;

endmodule
`default_nettype wire
